// File: rtl/tdc_daq_readout_arbiter_if.sv
// Channel-side streams and RTLink-side config/output bus of the TDC readout arbiter.
// slave = arbiter side, master = the driving environment.
interface tdc_daq_readout_arbiter_if #(
  parameter int NCH = 4,
  parameter int CHW = 2,
  parameter int DW  = 26
);
  logic [NCH-1:0]    ch_valid_i;
  logic [NCH*DW-1:0] ch_data_i;
  logic [NCH-1:0]    ch_last_i;
  logic [NCH-1:0]    ch_ready_o;
  logic              rtlink_stb_i;
  logic [1:0]        rtlink_adr_i;
  logic [15:0]       rtlink_data_i;
  logic              rtlink_stb_o;
  logic [DW+CHW:0]   rtlink_data_o;
  logic              timeout_o;

  modport slave (
    input  ch_valid_i, ch_data_i, ch_last_i,
    input  rtlink_stb_i, rtlink_adr_i, rtlink_data_i,
    output ch_ready_o, rtlink_stb_o, rtlink_data_o, timeout_o
  );

  modport master (
    output ch_valid_i, ch_data_i, ch_last_i,
    output rtlink_stb_i, rtlink_adr_i, rtlink_data_i,
    input  ch_ready_o, rtlink_stb_o, rtlink_data_o, timeout_o
  );
endinterface

// File: rtl/tdc_daq_readout_arbiter.sv
// Packet-granular round-robin merge of per-channel TDC readout streams into one
// RTLink input stream, with channel enable mask and stalled-packet timeout abort.
module tdc_daq_readout_arbiter #(
  parameter int NCH = 4,
  parameter int CHW = 2,
  parameter int DW  = 26,
  parameter int TW  = 16
) (
  input logic                     rio_phy_clk,
  input logic                     rio_phy_rst,
  tdc_daq_readout_arbiter_if.slave bus
);

  typedef enum logic {IDLE, BURST} state_t;

  state_t          state;
  logic [CHW-1:0]  grant, last_grant, pick;
  logic            found;
  logic [NCH-1:0]  mask, req;
  logic [TW-1:0]   tmo, idle_cnt, idle_nxt;
  logic            stb, tmo_pulse;
  logic [DW+CHW:0] dout;
  logic            accept, sel_last;
  logic [DW-1:0]   sel_data;

  assign req      = bus.ch_valid_i & mask;
  assign sel_data = bus.ch_data_i[grant*DW +: DW];
  assign sel_last = bus.ch_last_i[grant];
  assign accept   = (state == BURST) && bus.ch_valid_i[grant];
  assign idle_nxt = (idle_cnt == '1) ? idle_cnt : idle_cnt + 1'b1;

  assign bus.ch_ready_o    = (state == BURST) ? (NCH'(1) << grant) : '0;
  assign bus.rtlink_stb_o  = stb;
  assign bus.rtlink_data_o = dout;
  assign bus.timeout_o     = tmo_pulse;

  // First requester strictly after last_grant, wrapping, so each channel
  // waits at most NCH-1 packets.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    for (int i = 1; i <= NCH; i++) begin
      if (!found && req[CHW'((int'(last_grant) + i) % NCH)]) begin
        pick  = CHW'((int'(last_grant) + i) % NCH);
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge rio_phy_clk) begin
    if (rio_phy_rst) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= CHW'(NCH - 1);
      mask       <= '1;
      tmo        <= '0;
      idle_cnt   <= '0;
      stb        <= 1'b0;
      tmo_pulse  <= 1'b0;
      dout       <= '0;
    end else begin
      stb       <= 1'b0;
      tmo_pulse <= 1'b0;

      if (bus.rtlink_stb_i) begin
        case (bus.rtlink_adr_i)
          2'd0:    mask <= bus.rtlink_data_i[NCH-1:0];
          2'd1:    tmo  <= bus.rtlink_data_i[TW-1:0];
          default: ;
        endcase
      end

      case (state)
        IDLE: begin
          idle_cnt <= '0;
          if (found) begin
            grant      <= pick;
            last_grant <= pick;
            state      <= BURST;
          end
        end
        BURST: begin
          if (accept) begin
            stb      <= 1'b1;
            dout     <= {grant, sel_last, sel_data};
            idle_cnt <= '0;
            if (sel_last) state <= IDLE;
          end else begin
            idle_cnt <= idle_nxt;
            // >= keeps the abort firing if tmo is lowered below a running count
            if (tmo != '0 && idle_nxt >= tmo) begin
              stb       <= 1'b1;
              tmo_pulse <= 1'b1;
              dout      <= {grant, 1'b1, {DW{1'b1}}};
              state     <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tdc_daq_readout_arbiter.sv
// Directed bench: per-cycle vector table plus stream/stall sequences with hand-derived expectations.
module tb_tdc_daq_readout_arbiter;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  tdc_daq_readout_arbiter_if #(.NCH(4), .CHW(2), .DW(26)) bus ();

  tdc_daq_readout_arbiter #(.NCH(4), .CHW(2), .DW(26), .TW(16)) dut (
    .rio_phy_clk (clk),
    .rio_phy_rst (rst),
    .bus         (bus)
  );

  typedef struct {
    logic        rst;
    logic        cstb;
    logic [1:0]  cadr;
    logic [15:0] cdata;
    logic [3:0]  v;
    logic [3:0]  l;
    logic [25:0] d;
    logic [3:0]  e_rdy;
    logic        e_stb;
    logic [28:0] e_dat;
    logic        e_tmo;
  } vec_t;

  typedef int seq_t[8];

  vec_t vq[$];

  function automatic logic [28:0] ow(input int ch, input bit l, input logic [25:0] d);
    return {2'(ch), l, d};
  endfunction

  function automatic vec_t mk(input logic r, input logic cs, input logic [1:0] ca,
                              input logic [15:0] cd, input logic [3:0] v, input logic [3:0] l,
                              input logic [25:0] d, input logic [3:0] er, input logic es,
                              input logic [28:0] ed, input logic et);
    vec_t x;
    x.rst = r; x.cstb = cs; x.cadr = ca; x.cdata = cd;
    x.v = v; x.l = l; x.d = d;
    x.e_rdy = er; x.e_stb = es; x.e_dat = ed; x.e_tmo = et;
    return x;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.ch_valid_i    = '0;
    bus.ch_data_i     = '0;
    bus.ch_last_i     = '0;
    bus.rtlink_stb_i  = 1'b0;
    bus.rtlink_adr_i  = '0;
    bus.rtlink_data_i = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic cfg(input logic [1:0] adr, input logic [15:0] data);
    bus.rtlink_stb_i  = 1'b1;
    bus.rtlink_adr_i  = adr;
    bus.rtlink_data_i = data;
    @(negedge clk);
    bus.rtlink_stb_i  = 1'b0;
  endtask

  // All four channels valid continuously, 2-word packets per channel.
  // Packet p occupies outputs at cycles 2+3p and 3+3p; cycle 4+3p is the gap.
  task automatic run_stream(input string nm, input int ncyc, input seq_t seq,
                            input int cfg_cyc, input logic [3:0] cfg_mask);
    int cnt[4];
    logic [3:0] acc;
    int p, w, ch, prior;
    bit exp_stb;
    for (int k = 0; k < 4; k++) cnt[k] = 0;
    for (int c = 0; c < ncyc; c++) begin
      bus.ch_valid_i = 4'hf;
      for (int k = 0; k < 4; k++) begin
        bus.ch_data_i[k*26 +: 26] = 26'(k * 256 + cnt[k]);
        bus.ch_last_i[k]          = cnt[k][0];
      end
      bus.rtlink_stb_i  = (c == cfg_cyc);
      bus.rtlink_adr_i  = 2'd0;
      bus.rtlink_data_i = {12'b0, cfg_mask};
      exp_stb = (c >= 2) && (((c - 2) % 3) != 2);
      chk({nm, " stb"}, 32'(bus.rtlink_stb_o), 32'(exp_stb));
      if (exp_stb) begin
        p  = (c - 2) / 3;
        w  = (c - 2) % 3;
        ch = seq[p];
        prior = 0;
        for (int q = 0; q < p; q++) if (seq[q] == ch) prior++;
        chk({nm, " data"}, 32'(bus.rtlink_data_o), 32'(ow(ch, w[0], 26'(ch * 256 + 2 * prior + w))));
      end
      acc = bus.ch_valid_i & bus.ch_ready_o;
      @(negedge clk);
      for (int k = 0; k < 4; k++) if (acc[k]) cnt[k]++;
    end
    idle_inputs();
  endtask

  initial begin
    seq_t s;
    int   bad;
    vec_t r;

    // ignored config addresses; ch2 3-word packet
    vq.push_back(mk(0,1,2,16'h0000, 4'h0,4'h0,26'h0,   4'h0,0,29'h0,0));
    vq.push_back(mk(0,1,3,16'h0001, 4'h0,4'h0,26'h0,   4'h0,0,29'h0,0));
    vq.push_back(mk(0,0,0,16'h0,    4'h4,4'h0,26'h11,  4'h0,0,29'h0,0));
    vq.push_back(mk(0,0,0,16'h0,    4'h4,4'h0,26'h11,  4'h4,0,29'h0,0));
    vq.push_back(mk(0,0,0,16'h0,    4'h4,4'h0,26'h22,  4'h4,1,ow(2,0,26'h11),0));
    vq.push_back(mk(0,0,0,16'h0,    4'h4,4'h4,26'h33,  4'h4,1,ow(2,0,26'h22),0));
    vq.push_back(mk(0,0,0,16'h0,    4'h0,4'h0,26'h0,   4'h0,1,ow(2,1,26'h33),0));
    vq.push_back(mk(0,0,0,16'h0,    4'h0,4'h0,26'h0,   4'h0,0,29'h0,0));
    // timeout = 5, ch0 stalls after one word, then a fresh single-word packet
    vq.push_back(mk(0,1,1,16'h0005, 4'h0,4'h0,26'h0,   4'h0,0,29'h0,0));
    vq.push_back(mk(0,0,0,16'h0,    4'h1,4'h0,26'h55,  4'h0,0,29'h0,0));
    vq.push_back(mk(0,0,0,16'h0,    4'h1,4'h0,26'h55,  4'h1,0,29'h0,0));
    vq.push_back(mk(0,0,0,16'h0,    4'h0,4'h0,26'h0,   4'h1,1,ow(0,0,26'h55),0));
    for (int i = 0; i < 4; i++)
      vq.push_back(mk(0,0,0,16'h0,  4'h0,4'h0,26'h0,   4'h1,0,29'h0,0));
    vq.push_back(mk(0,0,0,16'h0,    4'h0,4'h0,26'h0,   4'h0,1,ow(0,1,26'h3ffffff),1));
    vq.push_back(mk(0,0,0,16'h0,    4'h1,4'h1,26'h66,  4'h0,0,29'h0,0));
    vq.push_back(mk(0,0,0,16'h0,    4'h1,4'h1,26'h66,  4'h1,0,29'h0,0));
    vq.push_back(mk(0,0,0,16'h0,    4'h0,4'h0,26'h0,   4'h0,1,ow(0,1,26'h66),0));
    // mask = ch1 only, reset mid-burst, then mask back to all ones -> ch0 first
    vq.push_back(mk(0,1,0,16'h0002, 4'h0,4'h0,26'h0,   4'h0,0,29'h0,0));
    vq.push_back(mk(0,0,0,16'h0,    4'hf,4'h0,26'ha0,  4'h0,0,29'h0,0));
    vq.push_back(mk(0,0,0,16'h0,    4'hf,4'h0,26'ha0,  4'h2,0,29'h0,0));
    vq.push_back(mk(1,0,0,16'h0,    4'hf,4'h0,26'ha0,  4'h2,1,ow(1,0,26'ha0),0));
    vq.push_back(mk(0,0,0,16'h0,    4'hf,4'h0,26'ha0,  4'h0,0,29'h0,0));
    vq.push_back(mk(0,0,0,16'h0,    4'hf,4'h0,26'ha0,  4'h1,0,29'h0,0));
    vq.push_back(mk(0,0,0,16'h0,    4'h0,4'h0,26'h0,   4'h1,1,ow(0,0,26'ha0),0));

    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    foreach (vq[i]) begin
      r = vq[i];
      rst               = r.rst;
      bus.rtlink_stb_i  = r.cstb;
      bus.rtlink_adr_i  = r.cadr;
      bus.rtlink_data_i = r.cdata;
      bus.ch_valid_i    = r.v;
      bus.ch_last_i     = r.l;
      bus.ch_data_i     = {4{r.d}};
      chk($sformatf("vec%0d ready", i), 32'(bus.ch_ready_o), 32'(r.e_rdy));
      chk($sformatf("vec%0d stb", i), 32'(bus.rtlink_stb_o), 32'(r.e_stb));
      chk($sformatf("vec%0d timeout", i), 32'(bus.timeout_o), 32'(r.e_tmo));
      if (r.e_stb) chk($sformatf("vec%0d data", i), 32'(bus.rtlink_data_o), 32'(r.e_dat));
      @(negedge clk);
    end
    rst = 1'b0;
    idle_inputs();

    // round-robin rotation with all channels valid
    do_reset();
    s = '{0, 1, 2, 3, 0, 0, 0, 0};
    run_stream("rr", 15, s, -1, 4'h0);

    // mask 1010: ch1/ch3 alternate
    do_reset();
    cfg(2'd0, 16'h000a);
    s = '{1, 3, 1, 3, 0, 0, 0, 0};
    run_stream("mask", 12, s, -1, 4'h0);

    // clear ch1 during its burst: burst completes, then ch3 only
    do_reset();
    cfg(2'd0, 16'h000a);
    s = '{1, 3, 3, 3, 0, 0, 0, 0};
    run_stream("maskchg", 12, s, 1, 4'h8);

    // tmo = 0: a 1000-cycle stall never aborts
    do_reset();
    bus.ch_valid_i = 4'b0010;
    bus.ch_data_i[26 +: 26] = 26'h77;
    chk("stall grant ready", 32'(bus.ch_ready_o), 32'h0);
    @(negedge clk);
    chk("stall burst ready", 32'(bus.ch_ready_o), 32'h2);
    @(negedge clk);
    bus.ch_valid_i = 4'b0000;
    chk("stall first stb", 32'(bus.rtlink_stb_o), 32'h1);
    chk("stall first data", 32'(bus.rtlink_data_o), 32'(ow(1, 0, 26'h77)));
    @(negedge clk);
    bad = 0;
    repeat (1000) begin
      if (bus.rtlink_stb_o !== 1'b0 || bus.timeout_o !== 1'b0 || bus.ch_ready_o !== 4'b0010) bad++;
      @(negedge clk);
    end
    chk("stall quiet cycles", 32'(bad), 32'h0);
    bus.ch_valid_i = 4'b0010;
    bus.ch_last_i  = 4'b0010;
    bus.ch_data_i[26 +: 26] = 26'h78;
    chk("resume ready", 32'(bus.ch_ready_o), 32'h2);
    @(negedge clk);
    idle_inputs();
    chk("resume stb", 32'(bus.rtlink_stb_o), 32'h1);
    chk("resume data", 32'(bus.rtlink_data_o), 32'(ow(1, 1, 26'h78)));
    @(negedge clk);
    chk("resume end ready", 32'(bus.ch_ready_o), 32'h0);
    chk("resume end stb", 32'(bus.rtlink_stb_o), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
